dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the MemRead/MemWrite interface that the main decoder drives through the datapath.
- Services one load or store at a time with a fixed, parameterised latency.
- Holds the pipeline with Busy until the access completes.
- Handles RV32I byte, half and word sizes, load sign/zero extension, and flags misaligned or illegal requests.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, WAIT cycles before commit; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- Funct3  in  3  access size and signedness, using the RV32I load/store encoding.
- Addr  in  32  byte address; the ALU result.
- WrData  in  32  store data; the low bytes are used.
- RdData  out  32  load result; registered; valid only while Done=1.
- Busy  out  1  stall to the pipeline; combinational.
- Done  out  1  one-cycle completion pulse.
- MisalignErr  out  1  error flag; valid while Done=1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, RdData=0, Done=0, MisalignErr=0, latched request cleared.
  - Memory array is not reset.
  - Reset during WAIT aborts the access; a pending store is never committed.
- Request: req = MemRead|MemWrite. The requester holds MemRead, MemWrite, Funct3, Addr and WrData stable until the cycle in which Done=1.
- FSM states:
  - IDLE:
    - req=0: stay in IDLE.
    - req=1 and legal: latch the request, counter=LATENCY-1, go to WAIT.
    - req=1 and illegal: go to ERR_RESP.
  - WAIT: counter decrements each cycle. When counter=0:
    - Store: commit the write at that edge.
    - Load: register RdData at that edge.
    - Go to RESP.
  - RESP: Done=1, MisalignErr=0, then go to IDLE.
  - ERR_RESP: Done=1, MisalignErr=1, RdData=0, no memory write, then go to IDLE.
- Busy = req & ~Done, combinational:
  - High in IDLE whenever req=1.
  - High throughout WAIT.
  - Low in RESP and ERR_RESP.
- Latency: request first seen in cycle T.
  - Legal access: Done in cycle T+LATENCY+1.
  - Illegal access: Done in cycle T+1.
- Back-to-back requests: the request in the RESP cycle is not re-accepted. A new request is accepted in the IDLE cycle that follows.
- Illegal requests:
  - MemRead=1 and MemWrite=1 together.
  - Load Funct3 of 011, 110 or 111.
  - Store Funct3 with bit 2 set, or Funct3=011.
  - Misalignment: halfword with Addr[0]=1; word with Addr[1:0]!=0.
- Addressing:
  - Word index = Addr[ADDR_W+1:2].
  - Higher address bits are ignored, so addresses wrap modulo the memory size.
  - Byte lane = Addr[1:0]; halfword lane = Addr[1].
- Loads:
  - 000 lb: byte, sign-extended.
  - 001 lh: halfword, sign-extended.
  - 010 lw: word.
  - 100 lbu: byte, zero-extended.
  - 101 lhu: halfword, zero-extended.
- Stores:
  - 000 sb: writes WrData[7:0] to the addressed lane.
  - 001 sh: writes WrData[15:0] to the addressed halfword.
  - 010 sw: writes the full word.
  - Unaddressed bytes of the word are unchanged (per-byte write enables).
- Outputs between responses: RdData holds its last value. Done and MisalignErr are 0 outside RESP and ERR_RESP.

Test Plan:
- Word round trip, LATENCY=2:
  - sw WrData=0xDEADBEEF, Addr=0x40 -> Busy high for 3 cycles; Done in cycle T+3.
  - Then lw Addr=0x40 -> RdData=0xDEADBEEF, MisalignErr=0.
- Byte and halfword lanes, extension:
  - sw 0x00000000 @0x10, then sb WrData=0x85 @0x13.
  - lw @0x10 -> 0x85000000.
  - lb @0x13 -> 0xFFFFFF85.
  - lbu @0x13 -> 0x00000085.
- Halfword lanes:
  - sh WrData=0x8001 @0x22.
  - lh @0x22 -> 0xFFFF8001.
  - lhu @0x22 -> 0x00008001.
  - lh @0x20 -> the previous low half, unchanged.
- Errors:
  - lw @0x41 -> Done in T+1, MisalignErr=1, RdData=0.
  - sw @0x42 -> same error response; a following lw @0x40 still returns the old word.
  - MemRead=MemWrite=1 -> error response.
- Reset mid-WAIT: sw 0x12345678 @0x80 over old value 0xCAFEF00D; drop rst_n in the first WAIT cycle.
  - Outputs go to 0 immediately.
  - After release, lw @0x80 -> 0xCAFEF00D.
- Wrap-around and back-to-back, ADDR_W=10:
  - sw 0xA5A5A5A5 @0x1000, then lw @0x0000 issued in the IDLE cycle right after Done -> 0xA5A5A5A5.
  - Exactly one idle cycle separates the two Busy windows.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: services one RV32I load/store at a time with a fixed
// wait latency, stalls the pipeline via Busy and flags illegal/misaligned requests.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Busy,
    output logic        Done,
    output logic        MisalignErr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_rddata;
    logic               r_done;
    logic               r_err;
    logic               r_store;
    logic [2:0]         r_f3;
    logic [ADDR_W-1:0]  r_widx;
    logic [1:0]         r_lane;
    logic [31:0]        r_wdata;
    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic               w_f3_ok;
    logic               w_misalign;
    logic               w_legal;
    logic               w_commit;
    logic               w_mem_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic [31:0]        w_rd_word;
    logic [7:0]         w_rd_byte;
    logic [15:0]        w_rd_half;
    logic [31:0]        w_load_data;
    logic               w_unused_addr;

    assign w_req = MemRead | MemWrite;
    assign Busy  = w_req & ~r_done;

    // Address bits above the word index alias onto the same memory
    assign w_unused_addr = ^Addr[31:ADDR_W+2];

    // Request legality: size/signedness encoding and natural alignment
    always_comb begin
        w_f3_ok    = 1'b0;
        w_misalign = 1'b0;
        if (MemWrite) begin
            w_f3_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
        end else begin
            w_f3_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                      (Funct3 == 3'b100) || (Funct3 == 3'b101);
        end
        case (Funct3[1:0])
            2'b01:   w_misalign = Addr[0];
            2'b10:   w_misalign = |Addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_legal  = ~(MemRead & MemWrite) & w_f3_ok & ~w_misalign;
    assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_mem_we = w_commit & r_store;

    // Store lane steering from the latched request
    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
        case (r_f3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << r_lane;
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = r_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        w_rd_word   = r_mem[r_widx];
        w_rd_byte   = w_rd_word[{r_lane, 3'b000} +: 8];
        w_rd_half   = w_rd_word[{r_lane[1], 4'b0000} +: 16];
        w_load_data = w_rd_word;
        case (r_f3)
            3'b000:  w_load_data = {{24{w_rd_byte[7]}}, w_rd_byte};
            3'b001:  w_load_data = {{16{w_rd_half[15]}}, w_rd_half};
            3'b100:  w_load_data = {24'd0, w_rd_byte};
            3'b101:  w_load_data = {16'd0, w_rd_half};
            default: w_load_data = w_rd_word;
        endcase
    end

    // Memory array is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_widx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Control FSM; Done/MisalignErr are set on entry to the response states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rddata <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_store  <= 1'b0;
            r_f3     <= '0;
            r_widx   <= '0;
            r_lane   <= '0;
            r_wdata  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_legal) begin
                            r_store <= MemWrite;
                            r_f3    <= Funct3;
                            r_widx  <= Addr[ADDR_W+1:2];
                            r_lane  <= Addr[1:0];
                            r_wdata <= WrData;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                            r_state <= S_WAIT;
                        end else begin
                            r_rddata <= '0;
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_state  <= S_ERR;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_store) begin
                            r_rddata <= w_load_data;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RdData      = r_rddata;
    assign Done        = r_done;
    assign MisalignErr = r_err;

endmodule
